// File: rtl/dcache_stb_responder.sv
// Store-buffer responder: accepts one store at a time, waits ACK_LAT cycles, pulses ack,
// and commits the enabled byte lanes into a small reset-cleared word array on leaving ACK.
module dcache_stb_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = 4,
    parameter int DEPTH          = 16,
    parameter int ACK_LAT        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
    input  logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
    input  logic                      stb2dcache_w_en,
    input  logic                      stb2dcache_req,
    input  logic                      dmem_sel_i,
    input  logic                      dcache_busy_i,
    output logic                      dcache2stb_ack,
    input  logic [$clog2(DEPTH)-1:0]  dbg_addr,
    output logic [DATA_WIDTH-1:0]     dbg_rdata,
    output logic [15:0]               wr_count
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t                    state_reg, state_next;
    logic [3:0]                cnt_reg, cnt_next;
    logic                      ack_reg, ack_next;
    logic [ADDR_WIDTH-1:0]     addr_reg;
    logic [DATA_WIDTH-1:0]     wdata_reg;
    logic [BYTE_SEL_WIDTH-1:0] sel_reg;
    logic                      wen_reg;
    logic [15:0]               wr_count_reg;
    logic                      accept;
    logic                      do_write;
    logic [IDX_W-1:0]          wr_idx;
    logic [DATA_WIDTH-1:0]     word_arr [DEPTH];
    logic                      unused_addr_bits;

    assign accept = (state_reg == IDLE) && stb2dcache_req && dmem_sel_i && !dcache_busy_i;
    assign wr_idx = addr_reg[IDX_W+1:2];
    // Byte offset and bits above the word index alias onto the same word.
    assign unused_addr_bits = ^{addr_reg[ADDR_WIDTH-1:IDX_W+2], addr_reg[1:0]};

    // State register and transaction latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ack_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            sel_reg   <= '0;
            wen_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ack_reg   <= ack_next;
            if (accept) begin
                addr_reg  <= stb2dcache_addr;
                wdata_reg <= stb2dcache_wdata;
                sel_reg   <= stb2dcache_sel_byte;
                wen_reg   <= stb2dcache_w_en;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next   = 4'(ACK_LAT);
                    state_next = (ACK_LAT > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg <= 4'd1) begin
                    state_next = ACK;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: ack is registered so it is high exactly while in ACK
    always_comb begin
        ack_next = (state_next == ACK);
        do_write = (state_reg == ACK) && wen_reg;
    end

    assign dcache2stb_ack = ack_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_reg <= '0;
        end else if (do_write && (wr_count_reg != 16'hFFFF)) begin
            wr_count_reg <= wr_count_reg + 16'd1;
        end
    end

    assign wr_count = wr_count_reg;

    // Word array is register-based so reset can clear it and reads stay combinational.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DATA_WIDTH-1:0] word_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    word_reg <= '0;
                end else if (do_write && (wr_idx == IDX_W'(gi))) begin
                    for (int b = 0; b < BYTE_SEL_WIDTH; b++) begin
                        if (sel_reg[b]) begin
                            word_reg[b*8 +: 8] <= wdata_reg[b*8 +: 8];
                        end
                    end
                end
            end
            assign word_arr[gi] = word_reg;
        end
    endgenerate

    assign dbg_rdata = word_arr[dbg_addr];

endmodule

// File: tb/tb_dcache_stb_responder.sv
// Directed bench for dcache_stb_responder: table of stores with hand-computed results
// on an ACK_LAT=2 instance, plus busy, reset-abort and ACK_LAT=0 back-to-back sequences.
module tb_dcache_stb_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic        w_en, req, dmem_sel, busy, ack;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_rdata;
    logic [15:0] wr_count;

    logic [31:0] z_addr, z_wdata;
    logic [3:0]  z_sel;
    logic        z_w_en, z_req, z_dmem_sel, z_busy, z_ack;
    logic [3:0]  z_dbg_addr;
    logic [31:0] z_dbg_rdata;
    logic [15:0] z_wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dcache_stb_responder #(.ACK_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .stb2dcache_addr(addr), .stb2dcache_wdata(wdata), .stb2dcache_sel_byte(sel),
        .stb2dcache_w_en(w_en), .stb2dcache_req(req), .dmem_sel_i(dmem_sel),
        .dcache_busy_i(busy), .dcache2stb_ack(ack),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .wr_count(wr_count)
    );

    dcache_stb_responder #(.ACK_LAT(0)) dut0 (
        .clk(clk), .rst(rst),
        .stb2dcache_addr(z_addr), .stb2dcache_wdata(z_wdata), .stb2dcache_sel_byte(z_sel),
        .stb2dcache_w_en(z_w_en), .stb2dcache_req(z_req), .dmem_sel_i(z_dmem_sel),
        .dcache_busy_i(z_busy), .dcache2stb_ack(z_ack),
        .dbg_addr(z_dbg_addr), .dbg_rdata(z_dbg_rdata), .wr_count(z_wr_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        wen;
        logic [3:0]  idx;
        logic [31:0] exp_word;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Present a request; caller is positioned at a negedge.
    task automatic launch(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic we, input logic [3:0] idx);
        addr = a; wdata = d; sel = s; w_en = we; req = 1'b1; dmem_sel = 1'b1; dbg_addr = idx;
    endtask

    // Wait for the acceptance edge, then scramble inputs and hold busy high.
    task automatic accept_edge();
        @(posedge clk);
        #1;
        req = 1'b0; addr = $urandom; wdata = $urandom; sel = 4'($urandom);
        w_en = 1'($urandom); dmem_sel = 1'($urandom); busy = 1'b1;
    endtask

    task automatic finish_txn(input string tag, input logic [3:0] idx,
                              input logic [31:0] exp_word, input logic [15:0] exp_cnt);
        int ack_cycles = 0;
        accept_edge();
        for (int k = 0; k <= LAT + 1; k++) begin
            @(negedge clk);
            check({tag, "_ack"}, {31'b0, ack}, {31'b0, (k == LAT)});
            if (ack) ack_cycles++;
        end
        busy = 1'b0;
        dbg_addr = idx;
        #1;
        check({tag, "_word"}, dbg_rdata, exp_word);
        check({tag, "_cnt"}, {16'b0, wr_count}, {16'b0, exp_cnt});
        $display("txn %s: word[%0d]=%h wr_count=%0d ack_cycles=%0d", tag, idx, dbg_rdata, wr_count, ack_cycles);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0008, 32'hDEADBEEF, 4'b1111, 1'b1, 4'd2,  32'hDEADBEEF, 16'd1};
        vecs[1] = '{32'h0000_0008, 32'h11223344, 4'b0101, 1'b1, 4'd2,  32'hDE22BE44, 16'd2};
        vecs[2] = '{32'h0000_0008, 32'hFFFFFFFF, 4'b1111, 1'b0, 4'd2,  32'hDE22BE44, 16'd2};
        vecs[3] = '{32'h0000_0047, 32'hA5A50F0F, 4'b1000, 1'b1, 4'd1,  32'hA5000000, 16'd3};
        vecs[4] = '{32'hFFFF_FFFC, 32'h12345678, 4'b0011, 1'b1, 4'd15, 32'h00005678, 16'd4};
        vecs[5] = '{32'h0000_0040, 32'hCAFEF00D, 4'b1111, 1'b1, 4'd0,  32'hCAFEF00D, 16'd5};
        vecs[6] = '{32'h0000_0048, 32'h00000099, 4'b0001, 1'b1, 4'd2,  32'hDE22BE99, 16'd6};

        rst = 1'b1; busy = 1'b0;
        z_addr = '0; z_wdata = '0; z_sel = '0; z_w_en = 1'b0; z_req = 1'b0;
        z_dmem_sel = 1'b1; z_busy = 1'b0; z_dbg_addr = '0;
        launch(vecs[0].addr, vecs[0].wdata, vecs[0].sel, vecs[0].wen, vecs[0].idx);
        repeat (3) @(negedge clk);
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_cnt", {16'b0, wr_count}, 32'd0);
        check("rst_word", dbg_rdata, 32'd0);
        check("rst_ack0", {31'b0, z_ack}, 32'd0);
        rst = 1'b0;

        // Table: first vector is accepted on the first edge after reset release
        for (int i = 0; i < 7; i++) begin
            if (i > 0) launch(vecs[i].addr, vecs[i].wdata, vecs[i].sel, vecs[i].wen, vecs[i].idx);
            finish_txn($sformatf("vec%0d", i), vecs[i].idx, vecs[i].exp_word, vecs[i].exp_cnt);
        end

        // Back-pressure holds off acceptance for 5 cycles
        launch(32'h0000_0024, 32'h600DCAFE, 4'b1111, 1'b1, 4'd9);
        busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("busy_noack", {31'b0, ack}, 32'd0);
        end
        check("busy_cnt", {16'b0, wr_count}, 32'd6);
        busy = 1'b0;
        finish_txn("busy", 4'd9, 32'h600DCAFE, 16'd7);

        // ACK_LAT=0, req held across four stores
        z_req = 1'b1; z_w_en = 1'b1; z_sel = 4'hF;
        z_addr = 32'h10; z_wdata = 32'h10101010;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("lat0_ack", {31'b0, z_ack}, {31'b0, (k % 2 == 0)});
            if (k % 2 == 0) begin
                z_addr  = 32'h10 + 32'(k / 2 + 1) * 4;
                z_wdata = 32'h10101010 * 32'(k / 2 + 2);
                if (k == 6) z_req = 1'b0;
            end
        end
        for (int w = 0; w < 4; w++) begin
            z_dbg_addr = 4'(4 + w);
            #1;
            check("lat0_word", z_dbg_rdata, 32'h10101010 * 32'(w + 1));
        end
        check("lat0_cnt", {16'b0, z_wr_count}, 32'd4);
        $display("txn lat0: 4 stores, wr_count=%0d", z_wr_count);
        @(negedge clk);

        // Reset during WAIT aborts the store
        launch(32'h0000_0004, 32'h77777777, 4'b1111, 1'b1, 4'd1);
        accept_edge();
        @(negedge clk);
        check("rstw_ack0", {31'b0, ack}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rstw_noack", {31'b0, ack}, 32'd0);
        end
        check("rstw_word", dbg_rdata, 32'd0);
        check("rstw_cnt", {16'b0, wr_count}, 32'd0);
        $display("txn rst_in_wait: word[1]=%h wr_count=%0d", dbg_rdata, wr_count);

        // Reset while in ACK suppresses the write
        launch(32'h0000_000C, 32'h55555555, 4'b1111, 1'b1, 4'd3);
        accept_edge();
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            check("rsta_ack", {31'b0, ack}, {31'b0, (k == LAT)});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; busy = 1'b0;
        check("rsta_noack", {31'b0, ack}, 32'd0);
        check("rsta_word", dbg_rdata, 32'd0);
        check("rsta_cnt", {16'b0, wr_count}, 32'd0);
        $display("txn rst_in_ack: word[3]=%h wr_count=%0d", dbg_rdata, wr_count);

        // Normal operation resumes after the abort
        launch(32'h0000_0004, 32'h0BADF00D, 4'b1111, 1'b1, 4'd1);
        finish_txn("post_rst", 4'd1, 32'h0BADF00D, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dcache_stb_responder.md
DCACHE_STB_RESPONDER -- requirements
Module: dcache_stb_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, store address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, store data width.
REQ-003 SHALL have parameter BYTE_SEL_WIDTH, default 4, byte-enable width (DATA_WIDTH/8).
REQ-004 SHALL have parameter DEPTH, default 16, number of data words in backing array (power of 2).
REQ-005 SHALL have parameter ACK_LAT, default 2, wait cycles between acceptance and ack (0..15).
REQ-006 SHALL have ports: clk input 1 clock; rst input 1 reset, synchronous, active-high (one clock, all state on rising edge of clk).
REQ-007 SHALL have ports: stb2dcache_addr input ADDR_WIDTH store address; stb2dcache_wdata input DATA_WIDTH store data; stb2dcache_sel_byte input BYTE_SEL_WIDTH byte enables.
REQ-008 SHALL have ports: stb2dcache_w_en input 1 write enable; stb2dcache_req input 1 request; dmem_sel_i input 1 data-memory select.
REQ-009 SHALL have ports: dcache_busy_i input 1 back-pressure, blocks new acceptance; dcache2stb_ack output 1 completion pulse.
REQ-010 SHALL have ports: dbg_addr input log2(DEPTH) word index; dbg_rdata output DATA_WIDTH combinational array read; wr_count output 16 completed-write counter.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-012 In IDLE, SHALL accept when stb2dcache_req=1, dmem_sel_i=1 and dcache_busy_i=0 at a rising edge; otherwise remain IDLE.
REQ-013 On acceptance SHALL latch addr, wdata, sel_byte and w_en, and load wait counter with ACK_LAT.
REQ-014 On acceptance SHALL go to WAIT if ACK_LAT>0, else directly to ACK.
REQ-015 In WAIT SHALL decrement counter each cycle and go to ACK when counter reaches 1 on that edge.
REQ-016 dcache2stb_ack SHALL be registered and high for exactly one cycle, in state ACK only, ACK_LAT+1 cycles after acceptance edge.
REQ-017 At the edge leaving ACK, if latched w_en=1, SHALL write latched byte lanes with sel_byte bit=1 into word addr[log2(DEPTH)+1:2]; lanes with bit=0 unchanged.
REQ-018 Address bits [1:0] and bits above the index SHALL be ignored (aliasing allowed).
REQ-019 Latched w_en=0 SHALL still produce ack, with no array write and no wr_count change.
REQ-020 wr_count SHALL increment by 1 on each completed write with w_en=1, saturating at 16'hFFFF.
REQ-021 ACK SHALL always return to IDLE; req sampled during ACK SHALL NOT be accepted, so back-to-back transactions are separated by at least one IDLE cycle.
REQ-022 Changes of req, addr, data or dmem_sel_i after acceptance SHALL NOT affect the in-flight transaction.
REQ-023 dcache_busy_i SHALL only gate acceptance in IDLE; an in-flight transaction SHALL complete regardless.
REQ-024 dbg_rdata SHALL reflect array contents combinationally; a write is visible the cycle after ack.

Reset
REQ-025 While rst=1 at a rising edge: state IDLE, counter 0, dcache2stb_ack=0, wr_count=0, latched registers 0, all array words 0.
REQ-026 rst asserted mid-transaction (WAIT or ACK) SHALL abort it: no array write, no ack in the following cycle, no wr_count increment.
REQ-027 First acceptance SHALL be possible at the first rising edge with rst=0.

Verification
REQ-028 ACK_LAT=2: req, addr=0x0000_0008, wdata=0xDEADBEEF, sel=4'b1111 accepted at edge t0 -> ack high only in cycle after t0+2; dbg_addr=2 gives 0xDEADBEEF next cycle; wr_count=1.
REQ-029 Word 2=0xDEADBEEF, write wdata=0x11223344 sel=4'b0101 to addr 0x8 -> dbg_rdata=0xDE22BE44.
REQ-030 dcache_busy_i=1 for 5 cycles with req held -> no acceptance, no ack; busy drops -> ack ACK_LAT+1 cycles after acceptance edge.
REQ-031 ACK_LAT=0, req held continuously for 4 stores -> each ack one cycle, ack separated by one low cycle, 4 correct words written, wr_count=4.
REQ-032 Accept write to addr 0x4, assert rst in WAIT -> no ack, word 1=0, wr_count=0; next req accepted normally.
REQ-033 req with w_en=0, addr 0x8 -> ack after ACK_LAT+1 cycles, word 2 unchanged, wr_count unchanged.
